// File: rtl/pi_loop_controller.sv
// ---------------------------------------------------------------------------
// pi_loop_controller
//
// Fixed-point PI regulator fed by network_wrapper. Turns a stream of signed
// ADC samples into a signed 14-bit DAC code. Everything runs in the
// rx_xcvr_clk (125 MHz) domain.
//
// Build option:
//   PI_ANTIWINDUP_EN  - when defined, the integrator is frozen while the
//                       output sits beyond a limit and the increment would
//                       push it further out (conditional integration).
//                       When undefined, the integrator only saturates at
//                       ACC_W bits.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   pi_enable_cmd / pi_reset_cmd      one-cycle pulses: go to RUN / clear
//                                     the loop and go to IDLE (reset wins)
//   pi_kp_coefficient (+_update_cmd)  unsigned Q7.FRAC_BITS proportional gain
//   pi_ti_coefficient (+_update_cmd)  unsigned Q7.FRAC_BITS gain per sample
//   pi_setpoint (+_update_cmd)        signed 27-bit setpoint
//   pi_limit_HI / pi_limit_LO         signed output limits, used live
//   adc_data / adc_valid              signed sample and its strobe
//   dac_code / dac_valid              signed output code, one strobe per sample
//   pi_running                        high while in RUN
//   pi_limit_err                      high while pi_limit_HI < pi_limit_LO
//
// Pipeline: S1 error, S2 multiply, S3 shift+saturate, S4 integrate+clamp.
// A sample accepted in cycle N shows dac_valid in cycle N+4.
// ---------------------------------------------------------------------------
module pi_loop_controller #(
    parameter int FRAC_BITS = 20,
    parameter int ADC_W     = 16,
    parameter int ACC_W     = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pi_enable_cmd,
    input  logic             pi_reset_cmd,
    input  logic [26:0]      pi_kp_coefficient,
    input  logic             pi_kp_coefficient_update_cmd,
    input  logic [26:0]      pi_ti_coefficient,
    input  logic             pi_ti_coefficient_update_cmd,
    input  logic [26:0]      pi_setpoint,
    input  logic             pi_setpoint_update_cmd,
    input  logic [13:0]      pi_limit_HI,
    input  logic [13:0]      pi_limit_LO,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [13:0]      dac_code,
    output logic             dac_valid,
    output logic             pi_running,
    output logic             pi_limit_err
);

    localparam int COEF_W = 27;
    localparam int ERR_W  = COEF_W + 1;
    localparam int PROD_W = 2 * ERR_W;
    localparam int DAC_W  = 14;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Parameter sets: shadow holds the latest update, active is what the
    // loop uses; pending marks a shadow value not yet promoted.
    logic [COEF_W-1:0] kp_shadow, ti_shadow, sp_shadow;
    logic [COEF_W-1:0] kp_active, ti_active, sp_active;
    logic              kp_pend, ti_pend, sp_pend;

    logic [COEF_W-1:0] kp_eff, ti_eff, sp_eff;
    logic              sample_take;
    logic              param_load;

    // Pipeline registers
    logic                     s1_valid, s2_valid, s3_valid;
    logic signed [ERR_W-1:0]  s1_err;
    logic [COEF_W-1:0]        s1_kp, s1_ti;
    logic signed [PROD_W-1:0] s2_p, s2_q;
    logic signed [ACC_W-1:0]  s3_p, s3_inc;
    logic signed [ACC_W-1:0]  integ;

    // S4 combinational results
    logic signed [ACC_W:0]    integ_sum, out_sum, hi_ext, lo_ext;
    logic signed [ACC_W-1:0]  integ_new, integ_next;
    logic [DAC_W-1:0]         code_next;

    // Saturate a shifted product to ACC_W: in range only if every bit above
    // the ACC_W sign bit equals it.
    function automatic logic signed [ACC_W-1:0] sat_prod(input logic signed [PROD_W-1:0] x);
        if (&x[PROD_W-1:ACC_W-1] || ~|x[PROD_W-1:ACC_W-1])
            return x[ACC_W-1:0];
        else if (x[PROD_W-1])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_sum(input logic signed [ACC_W:0] x);
        if (x[ACC_W] == x[ACC_W-1])
            return x[ACC_W-1:0];
        else if (x[ACC_W])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    // A sample entering in RUN already sees a pending value, so the whole
    // sample is processed with one consistent parameter set.
    assign kp_eff = kp_pend ? kp_shadow : kp_active;
    assign ti_eff = ti_pend ? ti_shadow : ti_active;
    assign sp_eff = sp_pend ? sp_shadow : sp_active;

    assign sample_take = (state == RUN) && adc_valid && !pi_reset_cmd;
    assign param_load  = (state == IDLE) || sample_take;

    // -----------------------------------------------------------------------
    // Control: state machine, status outputs, parameter shadow/active sets
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pi_running   <= 1'b0;
            pi_limit_err <= 1'b0;
            kp_shadow    <= '0;
            ti_shadow    <= '0;
            sp_shadow    <= '0;
            kp_active    <= '0;
            ti_active    <= '0;
            sp_active    <= '0;
            kp_pend      <= 1'b0;
            ti_pend      <= 1'b0;
            sp_pend      <= 1'b0;
        end else begin
            if (pi_reset_cmd) begin
                state      <= IDLE;
                pi_running <= 1'b0;
            end else if (pi_enable_cmd) begin
                state      <= RUN;
                pi_running <= 1'b1;
            end

            pi_limit_err <= ($signed(pi_limit_HI) < $signed(pi_limit_LO));

            if (param_load && kp_pend) kp_active <= kp_shadow;
            if (param_load && ti_pend) ti_active <= ti_shadow;
            if (param_load && sp_pend) sp_active <= sp_shadow;

            // A fresh update re-arms pending even on a promotion cycle.
            if (pi_kp_coefficient_update_cmd) begin
                kp_shadow <= pi_kp_coefficient;
                kp_pend   <= 1'b1;
            end else if (param_load) begin
                kp_pend   <= 1'b0;
            end

            if (pi_ti_coefficient_update_cmd) begin
                ti_shadow <= pi_ti_coefficient;
                ti_pend   <= 1'b1;
            end else if (param_load) begin
                ti_pend   <= 1'b0;
            end

            if (pi_setpoint_update_cmd) begin
                sp_shadow <= pi_setpoint;
                sp_pend   <= 1'b1;
            end else if (param_load) begin
                sp_pend   <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S4: integrate, sum, clamp
    // -----------------------------------------------------------------------
`ifdef PI_ANTIWINDUP_EN
    logic inc_pos, inc_neg;
    assign inc_pos = !s3_inc[ACC_W-1] && (|s3_inc);
    assign inc_neg = s3_inc[ACC_W-1];
`endif

    // NOTE: every branch of this block assigns every output (defaults first
    // where needed), so no latch is inferred.
    always_comb begin
        integ_sum = (ACC_W+1)'(integ) + (ACC_W+1)'(s3_inc);
        integ_new = sat_sum(integ_sum);
        out_sum   = (ACC_W+1)'(s3_p) + (ACC_W+1)'(integ_new);
        hi_ext    = (ACC_W+1)'($signed(pi_limit_HI));
        lo_ext    = (ACC_W+1)'($signed(pi_limit_LO));

        // Inverted limits: LO takes precedence.
        if (hi_ext < lo_ext)
            code_next = pi_limit_LO;
        else if (out_sum > hi_ext)
            code_next = pi_limit_HI;
        else if (out_sum < lo_ext)
            code_next = pi_limit_LO;
        else
            code_next = out_sum[DAC_W-1:0];

        integ_next = integ_new;
`ifdef PI_ANTIWINDUP_EN
        if ((out_sum > hi_ext && inc_pos) || (out_sum < lo_ext && inc_neg))
            integ_next = integ;
`endif
    end

    // -----------------------------------------------------------------------
    // Stage valids, integrator and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || pi_reset_cmd) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            dac_valid <= 1'b0;
            dac_code  <= '0;
            integ     <= '0;
        end else begin
            s1_valid  <= sample_take;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            dac_valid <= s3_valid;
            if (s3_valid) begin
                dac_code <= code_next;
                integ    <= integ_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S1..S3 data registers
    // -----------------------------------------------------------------------
    // NOTE: these data registers carry no reset; the stage valids qualify
    // them, so their power-up contents never reach an output.
    always_ff @(posedge clk) begin
        if (sample_take) begin
            s1_err <= {sp_eff[COEF_W-1], sp_eff}
                    - {{(ERR_W-ADC_W){adc_data[ADC_W-1]}}, adc_data};
            s1_kp  <= kp_eff;
            s1_ti  <= ti_eff;
        end
        if (s1_valid) begin
            // Gains are unsigned: zero-extend before the signed multiply.
            s2_p <= PROD_W'($signed({1'b0, s1_kp})) * PROD_W'(s1_err);
            s2_q <= PROD_W'($signed({1'b0, s1_ti})) * PROD_W'(s1_err);
        end
        if (s2_valid) begin
            s3_p   <= sat_prod(s2_p >>> FRAC_BITS);
            s3_inc <= sat_prod(s2_q >>> FRAC_BITS);
        end
    end

endmodule
